// File: rtl/pack_scheduler_pkg.sv
// Shared definitions for the ML-DSA t0/t1 packing scheduler: FSM encoding,
// per-polynomial word count and the legal job-size check.
package pack_scheduler_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LAUNCH = 3'd1,
      ST_WAIT   = 3'd2,
      ST_GAP    = 3'd3,
      ST_DONE   = 3'd4
   } sched_state_e;

   localparam int unsigned POLY_WORDS = 52;

   localparam logic [3:0] K_LEGAL_A = 4'd4;
   localparam logic [3:0] K_LEGAL_B = 4'd6;
   localparam logic [3:0] K_LEGAL_C = 4'd8;

   // Only the ML-DSA parameter sets (K = 4, 6, 8) are accepted as job sizes.
   function automatic logic mldsa_k_legal(input logic [3:0] k);
      logic legal_s;
      case (k)
         K_LEGAL_A, K_LEGAL_B, K_LEGAL_C: legal_s = 1'b1;
         default:                         legal_s = 1'b0;
      endcase
      return legal_s;
   endfunction

endpackage

// File: rtl/pack_addr_reloc.sv
// Combinational relocation of the converter's per-polynomial addresses into
// global RAM addresses; everything is forced to zero while the scheduler is idle.
module pack_addr_reloc #(
   parameter int COEF_AW = 8,
   parameter int WORD_AW = 6,
   parameter int GOUT_AW = 9
) (
   input  logic                 busy,
   input  logic [2:0]           poly_idx,
   input  logic [GOUT_AW-1:0]   out_base,
   input  logic                 conv_in_en,
   input  logic [COEF_AW-1:0]   conv_in_addr,
   input  logic                 conv_out_en,
   input  logic [WORD_AW-1:0]   conv_out_addr,
   output logic                 mem_in_en,
   output logic [3+COEF_AW-1:0] mem_in_addr,
   output logic                 mem_out_en,
   output logic [GOUT_AW-1:0]   mem_out_addr
);

   // Relocate addresses and gate enables with busy.
   always_comb begin
      mem_in_en    = busy & conv_in_en;
      mem_out_en   = busy & conv_out_en;
      mem_in_addr  = '0;
      mem_out_addr = '0;
      if (busy) begin
         mem_in_addr  = {poly_idx, conv_in_addr};
         mem_out_addr = out_base + GOUT_AW'(conv_out_addr);
      end else begin
         mem_in_addr  = '0;
         mem_out_addr = '0;
      end
   end

endmodule

// File: rtl/pack_scheduler.sv
// Runs the 13-to-64-bit packing converter once per polynomial of a K-polynomial
// job, relocating its addresses and flagging illegal sizes or a stalled converter.
module pack_scheduler #(
   parameter int K_MAX      = 8,
   parameter int COEF_AW    = 8,
   parameter int WORD_AW    = 6,
   parameter int POLY_WORDS = pack_scheduler_pkg::POLY_WORDS,
   parameter int GOUT_AW    = 9,
   parameter int TIMEOUT    = 300
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 req,
   input  logic [3:0]           k_cfg,
   output logic                 busy,
   output logic                 job_done,
   output logic                 err,
   output logic                 conv_start,
   input  logic                 conv_done,
   input  logic                 conv_in_en,
   input  logic [COEF_AW-1:0]   conv_in_addr,
   input  logic                 conv_out_en,
   input  logic [WORD_AW-1:0]   conv_out_addr,
   output logic                 mem_in_en,
   output logic [3+COEF_AW-1:0] mem_in_addr,
   output logic                 mem_out_en,
   output logic [GOUT_AW-1:0]   mem_out_addr
);
   import pack_scheduler_pkg::*;

   localparam int PIDX_W = $clog2(K_MAX);
   localparam int TMO_W  = $clog2(TIMEOUT + 1);

   sched_state_e        state_r, state_s;
   logic [3:0]          k_r;
   logic [PIDX_W-1:0]   poly_idx_r;
   logic [GOUT_AW-1:0]  out_base_r;
   logic [TMO_W-1:0]    tmo_cnt_r;
   logic                busy_r, job_done_r, err_r, conv_start_r;
   logic                accept_s, reject_s, tmo_hit_s, last_poly_s;

   assign last_poly_s = (4'(poly_idx_r) == (k_r - 4'd1));

   // Next-state decode; conv_done takes priority over the timeout in WAIT.
   always_comb begin
      state_s   = state_r;
      accept_s  = 1'b0;
      reject_s  = 1'b0;
      tmo_hit_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (req) begin
               if (mldsa_k_legal(k_cfg)) begin
                  accept_s = 1'b1;
                  state_s  = ST_LAUNCH;
               end else begin
                  reject_s = 1'b1;
               end
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_LAUNCH: state_s = ST_WAIT;
         ST_WAIT: begin
            if (conv_done) begin
               state_s = ST_GAP;
            end else if (tmo_cnt_r == TMO_W'(TIMEOUT - 1)) begin
               tmo_hit_s = 1'b1;
               state_s   = ST_DONE;
            end else begin
               state_s = ST_WAIT;
            end
         end
         ST_GAP:  state_s = last_poly_s ? ST_DONE : ST_LAUNCH;
         ST_DONE: state_s = ST_IDLE;
         default: state_s = ST_IDLE;
      endcase
   end

   // State, job counters and registered status outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r      <= ST_IDLE;
         k_r          <= 4'd0;
         poly_idx_r   <= '0;
         out_base_r   <= '0;
         tmo_cnt_r    <= '0;
         busy_r       <= 1'b0;
         job_done_r   <= 1'b0;
         err_r        <= 1'b0;
         conv_start_r <= 1'b0;
      end else begin
         state_r      <= state_s;
         busy_r       <= (state_s != ST_IDLE);
         conv_start_r <= (state_s == ST_LAUNCH);
         job_done_r   <= (state_r == ST_GAP) && last_poly_s;
         err_r        <= reject_s | tmo_hit_s;
         if (accept_s) begin
            k_r        <= k_cfg;
            poly_idx_r <= '0;
            out_base_r <= '0;
         end else if (state_r == ST_GAP) begin
            poly_idx_r <= poly_idx_r + PIDX_W'(1);
            out_base_r <= out_base_r + GOUT_AW'(POLY_WORDS);
         end else begin
            poly_idx_r <= poly_idx_r;
            out_base_r <= out_base_r;
         end
         if (state_r == ST_LAUNCH) begin
            tmo_cnt_r <= '0;
         end else if ((state_r == ST_WAIT) && !conv_done) begin
            tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
         end else begin
            tmo_cnt_r <= tmo_cnt_r;
         end
      end
   end

   assign busy       = busy_r;
   assign job_done   = job_done_r;
   assign err        = err_r;
   assign conv_start = conv_start_r;

   pack_addr_reloc #(
      .COEF_AW (COEF_AW),
      .WORD_AW (WORD_AW),
      .GOUT_AW (GOUT_AW)
   ) u_reloc (
      .busy          (busy_r),
      .poly_idx      (poly_idx_r[2:0]),
      .out_base      (out_base_r),
      .conv_in_en    (conv_in_en),
      .conv_in_addr  (conv_in_addr),
      .conv_out_en   (conv_out_en),
      .conv_out_addr (conv_out_addr),
      .mem_in_en     (mem_in_en),
      .mem_in_addr   (mem_in_addr),
      .mem_out_en    (mem_out_en),
      .mem_out_addr  (mem_out_addr)
   );

endmodule

// File: tb/tb_pack_scheduler.sv
// Self-checking bench for pack_scheduler: a converter model with programmable
// latency plus a cycle-position reference derived from the job timing rules.
module tb_pack_scheduler;
   localparam int COEF_AW = 8;
   localparam int WORD_AW = 6;
   localparam int GOUT_AW = 9;
   localparam int PW      = 52;
   localparam int TMO     = 300;

   logic                 clk = 1'b0;
   logic                 reset;
   logic                 req;
   logic [3:0]           k_cfg;
   logic                 busy, job_done, err, conv_start;
   logic                 conv_done;
   logic                 conv_in_en;
   logic [COEF_AW-1:0]   conv_in_addr;
   logic                 conv_out_en;
   logic [WORD_AW-1:0]   conv_out_addr;
   logic                 mem_in_en;
   logic [3+COEF_AW-1:0] mem_in_addr;
   logic                 mem_out_en;
   logic [GOUT_AW-1:0]   mem_out_addr;

   int checks = 0;
   int errors = 0;

   int conv_lat  = 60;
   bit conv_hang = 1'b0;
   bit conv_spur = 1'b0;
   bit cv_active;
   int cv_cnt;
   int model_poly;
   int exp_poly;
   int out_seen [512];

   always #5 clk = ~clk;

   pack_scheduler #(
      .K_MAX(8), .COEF_AW(COEF_AW), .WORD_AW(WORD_AW),
      .POLY_WORDS(PW), .GOUT_AW(GOUT_AW), .TIMEOUT(TMO)
   ) dut (
      .clk(clk), .reset(reset), .req(req), .k_cfg(k_cfg),
      .busy(busy), .job_done(job_done), .err(err), .conv_start(conv_start),
      .conv_done(conv_done), .conv_in_en(conv_in_en), .conv_in_addr(conv_in_addr),
      .conv_out_en(conv_out_en), .conv_out_addr(conv_out_addr),
      .mem_in_en(mem_in_en), .mem_in_addr(mem_in_addr),
      .mem_out_en(mem_out_en), .mem_out_addr(mem_out_addr)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   // Converter model: emits 52 words then conv_done in its L-th busy cycle.
   initial begin
      conv_done = 1'b0; conv_in_en = 1'b0; conv_out_en = 1'b0;
      conv_in_addr = '0; conv_out_addr = '0;
      cv_active = 1'b0; cv_cnt = 0; model_poly = 0; exp_poly = 0;
      forever begin
         @(negedge clk);
         if (!busy) begin
            cv_active  = 1'b0;
            model_poly = 0;
         end
         conv_done = 1'b0; conv_in_en = 1'b0; conv_out_en = 1'b0;
         if (cv_active) begin
            cv_cnt++;
            conv_in_en    = 1'b1;
            conv_in_addr  = COEF_AW'($urandom);
            conv_out_en   = (cv_cnt <= PW);
            conv_out_addr = WORD_AW'(cv_cnt - 1);
            if (!conv_hang && cv_cnt == conv_lat) begin
               conv_done = 1'b1;
               cv_active = 1'b0;
            end
            #1;
            chk("mem_in_en", 32'(mem_in_en), 32'd1);
            chk("mem_in_addr", 32'(mem_in_addr), 32'((exp_poly % 8) * 256 + int'(conv_in_addr)));
            chk("mem_out_en", 32'(mem_out_en), 32'(conv_out_en));
            if (conv_out_en) begin
               chk("mem_out_addr", 32'(mem_out_addr), 32'(exp_poly * PW + int'(conv_out_addr)));
               out_seen[int'(mem_out_addr)]++;
            end
         end else begin
            conv_done = conv_spur && busy;
            if (conv_start) begin
               cv_active = 1'b1;
               cv_cnt    = 0;
               exp_poly  = model_poly;
               if (model_poly == 0) begin
                  for (int a = 0; a < 512; a++) out_seen[a] = 0;
               end
               model_poly++;
            end
         end
      end
   end

   // One job: expected outputs at cycle n after acceptance follow from
   // LAUNCH(1) + WAIT(L) + GAP(1) per polynomial, DONE at 1 + k*(L+2).
   task automatic run_job(input int k, input int lat, input bit hold, input bit hang);
      int done_n;
      bit es;
      done_n   = hang ? (TMO + 2) : (1 + k * (lat + 2));
      conv_lat = lat;
      @(negedge clk);
      k_cfg = 4'(k);
      req   = 1'b1;
      for (int n = 1; n <= done_n + 1; n++) begin
         @(negedge clk);
         es = hang ? (n == 1) : ((((n - 1) % (lat + 2)) == 0) && (n < done_n));
         chk("conv_start", 32'(conv_start), 32'(es));
         chk("busy", 32'(busy), 32'(n <= done_n));
         chk("job_done", 32'(job_done), 32'(!hang && n == done_n));
         chk("err", 32'(err), 32'(hang && n == done_n));
         if ((!hold && n == 1) || n == done_n) req = 1'b0;
      end
      if (!hang) begin
         for (int a = 0; a < 512; a++)
            chk("out_cover", 32'(out_seen[a]), (a < k * PW) ? 32'd1 : 32'd0);
      end
   endtask

   initial begin
      int kr, lr;
      reset = 1'b1; req = 1'b0; k_cfg = 4'd0;
      #12;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_job_done", 32'(job_done), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_conv_start", 32'(conv_start), 32'd0);
      chk("rst_mem_in_addr", 32'(mem_in_addr), 32'd0);
      chk("rst_mem_out_addr", 32'(mem_out_addr), 32'd0);
      @(negedge clk);
      reset = 1'b0;

      run_job(4, 130, 1'b0, 1'b0);
      run_job(8, int'($urandom_range(53, 140)), 1'b0, 1'b0);
      chk("k8_last_word", 32'(out_seen[415]), 32'd1);
      chk("k8_past_end", 32'(out_seen[416]), 32'd0);

      // Illegal size: one err pulse, nothing launched.
      @(negedge clk);
      k_cfg = 4'd5; req = 1'b1;
      @(negedge clk);
      req = 1'b0;
      chk("bad_k_err", 32'(err), 32'd1);
      chk("bad_k_busy", 32'(busy), 32'd0);
      chk("bad_k_start", 32'(conv_start), 32'd0);
      @(negedge clk);
      chk("bad_k_err_once", 32'(err), 32'd0);
      chk("bad_k_busy2", 32'(busy), 32'd0);
      chk("bad_k_start2", 32'(conv_start), 32'd0);
      run_job(6, int'($urandom_range(53, 100)), 1'b0, 1'b0);

      // Stalled converter, then a normal job.
      conv_hang = 1'b1;
      run_job(4, 1000, 1'b0, 1'b1);
      conv_hang = 1'b0;
      run_job(4, int'($urandom_range(53, 90)), 1'b0, 1'b0);

      // req held throughout plus spurious conv_done outside WAIT.
      conv_spur = 1'b1;
      run_job(4 + 2 * int'($urandom_range(0, 2)), int'($urandom_range(53, 90)), 1'b1, 1'b0);
      conv_spur = 1'b0;

      // Asynchronous reset in the middle of poly 2's WAIT.
      conv_lat = 60;
      @(negedge clk);
      k_cfg = 4'd4; req = 1'b1;
      @(negedge clk);
      req = 1'b0;
      repeat (129) @(negedge clk);
      chk("pre_rst_busy", 32'(busy), 32'd1);
      chk("pre_rst_in_en", 32'(mem_in_en), 32'd1);
      #2;
      reset = 1'b1;
      #1;
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_conv_start", 32'(conv_start), 32'd0);
      chk("arst_job_done", 32'(job_done), 32'd0);
      chk("arst_err", 32'(err), 32'd0);
      chk("arst_mem_in_en", 32'(mem_in_en), 32'd0);
      chk("arst_mem_out_en", 32'(mem_out_en), 32'd0);
      chk("arst_mem_in_addr", 32'(mem_in_addr), 32'd0);
      chk("arst_mem_out_addr", 32'(mem_out_addr), 32'd0);
      @(negedge clk);
      @(negedge clk);
      chk("arst_hold_job_done", 32'(job_done), 32'd0);
      chk("arst_hold_err", 32'(err), 32'd0);
      reset = 1'b0;
      run_job(4, int'($urandom_range(53, 90)), 1'b0, 1'b0);

      // A couple of randomized legal jobs.
      for (int j = 0; j < 2; j++) begin
         kr = 4 + 2 * int'($urandom_range(0, 2));
         lr = int'($urandom_range(53, 120));
         run_job(kr, lr, 1'b0, 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
